cordic_range_reduce: RTL and testbench

- Upstream front-end for the cordic_sine core. The core converges only for angles in [-pi/2, +pi/2].
- This block accepts any full-circle phase and folds it into that range. It drives the core's load/angle interface and waits for its done. It then applies the quadrant sign fix to the core's cos/sin results.
- It presents the fixed result through a valid/ready handshake to downstream consumers (e.g. NCO/mixer logic).

---
 rtl/cordic_pkg.sv | 35 +++
 rtl/cordic_quadrant_fold.sv | 47 ++++
 rtl/cordic_range_reduce.sv | 116 +++++++++++
 tb/tb_cordic_range_reduce.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC front-end blocks.
//   Q_W                  : sample width of the q13/q14 signed words
//   PI/HALF_PI/TWO_PI    : angle constants in q13 radians
//   state_t              : range-reduction controller states
//   negate_q()           : two's-complement negate, optionally saturating
package cordic_pkg;

  localparam int Q_W         = 16;
  localparam int PI_Q13      = 25736;
  localparam int HALF_PI_Q13 = 12868;
  localparam int TWO_PI_Q13  = 51472;

  localparam logic signed [Q_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [Q_W-1:0] Q_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // -Q_MIN does not exist in Q_W bits; with sat set it clips to Q_MAX,
  // otherwise it wraps back to Q_MIN as plain two's complement would.
  function automatic logic signed [Q_W-1:0] negate_q(
    input logic signed [Q_W-1:0] v,
    input logic                  sat
  );
    logic signed [Q_W-1:0] r;
    if (v == Q_MIN) r = sat ? Q_MAX : Q_MIN;
    else            r = -v;
    return r;
  endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Combinational quadrant fold for a full-circle q13 phase.
//   in_angle      : signed q13 phase, any 16-bit code (about +/-4 rad)
//   reduced_angle : signed q14 angle in [-pi/2, +pi/2] for the CORDIC core
//   neg_cos       : 1 when the angle was mirrored about +/-pi/2, so the
//                   core's cosine must be negated (sine is unchanged)
module cordic_quadrant_fold
  import cordic_pkg::*;
(
  input  logic signed [Q_W-1:0] in_angle,
  output logic signed [Q_W-1:0] reduced_angle,
  output logic                  neg_cos
);

  // Two guard bits: the wrap and the fold can both exceed the q13 range.
  localparam logic signed [17:0] PI      = 18'(PI_Q13);
  localparam logic signed [17:0] HALF_PI = 18'(HALF_PI_Q13);
  localparam logic signed [17:0] TWO_PI  = 18'(TWO_PI_Q13);

  logic signed [17:0] a_ext;
  logic signed [17:0] a_wrap;
  logic signed [17:0] r;

  assign a_ext = {{2{in_angle[Q_W-1]}}, in_angle};

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    a_wrap = a_ext;
    if (a_ext > PI)       a_wrap = a_ext - TWO_PI;
    else if (a_ext < -PI) a_wrap = a_ext + TWO_PI;

    r       = a_wrap;
    neg_cos = 1'b0;
    // Exactly +/-HALF_PI stays put: the comparisons are strict.
    if (a_wrap > HALF_PI) begin
      r       = PI - a_wrap;
      neg_cos = 1'b1;
    end else if (a_wrap < -HALF_PI) begin
      r       = -PI - a_wrap;
      neg_cos = 1'b1;
    end
  end

  // |r| <= HALF_PI, so the q13 -> q14 doubling always fits Q_W bits.
  assign reduced_angle = Q_W'(r <<< 1);

endmodule

// File: rtl/cordic_range_reduce.sv
// Front-end for cordic_sine: folds a full-circle phase into the core's
// convergence range, runs one core transaction, fixes the cosine sign and
// presents the result on a valid/ready output.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready     : phase handshake (in_ready only while idle)
//   in_angle              : signed q13 phase
//   core_load/core_angle  : one-cycle load pulse and q14 angle to the core
//   core_done/core_co/so  : core completion and q14 cos/sin results
//   out_valid/out_ready   : result handshake, result held until accepted
//   out_cos/out_sin       : signed q14 cos/sin of in_angle
//   out_err               : core timed out; out_cos/out_sin forced to 0
module cordic_range_reduce
  import cordic_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit TOL_SAT        = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [Q_W-1:0] in_angle,
  output logic                  core_load,
  output logic signed [Q_W-1:0] core_angle,
  input  logic                  core_done,
  input  logic signed [Q_W-1:0] core_co,
  input  logic signed [Q_W-1:0] core_so,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [Q_W-1:0] out_cos,
  output logic signed [Q_W-1:0] out_sin,
  output logic                  out_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  neg_cos;
  logic signed [Q_W-1:0] fold_angle;
  logic                  fold_neg_cos;
  logic                  tmo_hit;

  cordic_quadrant_fold u_fold (
    .in_angle      (in_angle),
    .reduced_angle (fold_angle),
    .neg_cos       (fold_neg_cos)
  );

  // WAIT entry clears the counter; it then advances once per waiting cycle,
  // so the abort lands exactly TIMEOUT_CYCLES edges after WAIT entry.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  assign in_ready  = (state == IDLE);
  assign core_load = (state == LOAD);
  assign out_valid = (state == OUT);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)             state_nxt = LOAD;
      LOAD:                              state_nxt = WAIT;
      WAIT:    if (core_done || tmo_hit) state_nxt = OUT;
      OUT:     if (out_ready)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples its inputs from before the edge, whatever the order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_angle <= '0;
      neg_cos    <= 1'b0;
      tmo_cnt    <= '0;
      out_cos    <= '0;
      out_sin    <= '0;
      out_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // core_angle stays frozen from here until the next accept.
          if (in_valid) begin
            core_angle <= fold_angle;
            neg_cos    <= fold_neg_cos;
          end
        end
        LOAD: tmo_cnt <= '0;
        WAIT: begin
          // core_done is only looked at here, so a level left over from an
          // earlier or abandoned transaction cannot complete this one early.
          if (core_done) begin
            out_sin <= core_so;
            out_cos <= neg_cos ? negate_q(core_co, TOL_SAT) : core_co;
            out_err <= 1'b0;
          end else if (tmo_hit) begin
            out_sin <= '0;
            out_cos <= '0;
            out_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Bench for cordic_range_reduce. A behavioural stand-in for cordic_sine
// answers each load with rounded q14 cos/sin after a programmable latency
// (or never, or with forced values). Expected results are derived from the
// unreduced input phase and queued when a phase is driven; they are popped
// and compared when the DUT presents its result.
module tb_cordic_range_reduce;

  localparam int TMO = 64;
  localparam int TOL = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_angle = '0;
  logic               core_load;
  logic signed [15:0] core_angle;
  logic               core_done = 1'b0;
  logic signed [15:0] core_co = '0;
  logic signed [15:0] core_so = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_cos;
  logic signed [15:0] out_sin;
  logic               out_err;

  cordic_range_reduce #(.TIMEOUT_CYCLES(TMO), .TOL_SAT(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_angle   (in_angle),
    .core_load  (core_load),
    .core_angle (core_angle),
    .core_done  (core_done),
    .core_co    (core_co),
    .core_so    (core_so),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cos    (out_cos),
    .out_sin    (out_sin),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cos_v;
    int   sin_v;
    logic err;
    int   tol;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   load_cnt = 0;
  int   load_before = 0;

  function automatic int q14(input real x);
    real s;
    s = x * 16384.0;
    return (s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5);
  endfunction

  // ---------------- core stand-in ----------------
  int                 core_lat = 3;
  bit                 core_en = 1'b1;
  bit                 core_ovr = 1'b0;
  logic signed [15:0] ovr_co = '0;
  logic signed [15:0] ovr_so = '0;
  int                 core_k = 0;
  bit                 core_busy = 1'b0;
  logic signed [15:0] cap_angle = '0;

  // Done rises core_lat edges after the edge that samples core_load.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_load) begin
      core_busy <= 1'b1;
      core_k    <= 1;
      cap_angle <= core_angle;
    end else if (core_busy) begin
      if (core_en && core_k == core_lat) begin
        core_done <= 1'b1;
        core_busy <= 1'b0;
        core_co   <= core_ovr ? ovr_co : 16'(q14($cos(real'(int'(cap_angle)) / 16384.0)));
        core_so   <= core_ovr ? ovr_so : 16'(q14($sin(real'(int'(cap_angle)) / 16384.0)));
      end else begin
        core_k <= core_k + 1;
      end
    end
  end

  always @(posedge clk) if (core_load) load_cnt <= load_cnt + 1;

  // ---------------- checking helpers ----------------
  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp, input int tol);
    n_cmp++;
    assert ((((obs - exp) <= tol) && ((exp - obs) <= tol)) === 1'b1) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_trig(input logic signed [15:0] ang);
    exp_t e;
    e.cos_v = q14($cos(real'(int'(ang)) / 8192.0));
    e.sin_v = q14($sin(real'(int'(ang)) / 8192.0));
    e.err   = 1'b0;
    e.tol   = TOL;
    sb.push_back(e);
  endtask

  task automatic push_exact(input int c, input int s, input logic err);
    exp_t e;
    e.cos_v = c;
    e.sin_v = s;
    e.err   = err;
    e.tol   = 0;
    sb.push_back(e);
  endtask

  // Returns in the LOAD cycle, one cycle after the accepting edge.
  task automatic drive_in(input logic signed [15:0] ang, input int exp_core);
    int budget;
    budget   = 0;
    in_angle = ang;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && budget < 100) begin
      step();
      budget++;
    end
    check_eq("in_ready_before_accept", in_ready, 1);
    load_before = load_cnt;
    step();
    in_valid = 1'b0;
    check_eq("core_load_pulse", core_load, 1);
    check_eq("core_angle", core_angle, exp_core);
    check_eq("in_ready_busy", in_ready, 0);
  endtask

  task automatic wait_valid(input int exp_lat);
    int cycles;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 400) begin
      step();
      cycles++;
    end
    check_eq("out_valid_rise", out_valid, 1);
    check_eq("accept_to_valid", cycles, exp_lat);
  endtask

  task automatic take_result(input int exp_core);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    check_tol("out_cos", out_cos, e.cos_v, e.tol);
    check_tol("out_sin", out_sin, e.sin_v, e.tol);
    check_eq("out_err", out_err, e.err);
    check_eq("core_load_count", load_cnt - load_before, 1);
    check_eq("core_angle_held", core_angle, exp_core);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("out_valid_drop", out_valid, 0);
    check_eq("in_ready_after_take", in_ready, 1);
  endtask

  task automatic run_txn(input logic signed [15:0] ang, input int exp_core, input int lat);
    core_lat = lat;
    push_trig(ang);
    drive_in(ang, exp_core);
    wait_valid(2 + lat);
    take_result(exp_core);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic signed [15:0] h_cos;
    logic signed [15:0] h_sin;
    logic               h_err;

    #3;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_core_load", core_load, 0);
    check_eq("rst_core_angle", core_angle, 0);
    check_eq("rst_out_cos", out_cos, 0);
    check_eq("rst_out_sin", out_sin, 0);
    check_eq("rst_out_err", out_err, 0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("rst_in_ready", in_ready, 1);

    run_txn(16'sd4593,   9186,   3);
    run_txn(16'sd17157,  17158,  1);
    run_txn(-16'sd17157, -17158, 6);
    run_txn(16'sd12868,  25736,  2);
    run_txn(-16'sd12868, -25736, 2);
    run_txn(16'sd30000,  -8528,  4);
    run_txn(-16'sd32768, 14064,  3);

    // Result held under back-pressure while another phase is offered.
    core_lat = 3;
    push_trig(16'sd8579);
    drive_in(16'sd8579, 17158);
    wait_valid(5);
    h_cos = out_cos;
    h_sin = out_sin;
    h_err = out_err;
    in_angle = 16'sd500;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_cos", out_cos, h_cos);
      check_eq("hold_sin", out_sin, h_sin);
      check_eq("hold_err", out_err, h_err);
      check_eq("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    take_result(17158);

    // Most negative core cosine on a folded angle saturates; unfolded passes.
    core_ovr = 1'b1;
    ovr_co   = -16'sd32768;
    ovr_so   = 16'sd1234;
    core_lat = 2;
    push_exact(32767, 1234, 1'b0);
    drive_in(16'sd17157, 17158);
    wait_valid(4);
    take_result(17158);
    push_exact(-32768, 1234, 1'b0);
    drive_in(16'sd100, 200);
    wait_valid(4);
    take_result(200);
    core_ovr = 1'b0;

    // Core never answers: abort TMO edges after WAIT entry.
    core_en = 1'b0;
    push_exact(0, 0, 1'b1);
    drive_in(16'sd1000, 2000);
    wait_valid(1 + TMO);
    take_result(2000);
    core_en = 1'b1;

    // Reset while waiting; the core's late done must be ignored.
    core_lat = 20;
    drive_in(16'sd4593, 9186);
    for (int i = 0; i < 4; i++) step();
    reset_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_core_load", core_load, 0);
    check_eq("midrst_core_angle", core_angle, 0);
    check_eq("midrst_out_cos", out_cos, 0);
    check_eq("midrst_out_sin", out_sin, 0);
    check_eq("midrst_out_err", out_err, 0);
    sb.delete();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) step();
    check_eq("late_done_ignored", out_valid, 0);
    check_eq("late_done_in_ready", in_ready, 1);
    run_txn(16'sd8579, 17158, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000 ns");
    $fatal(1, "bench timed out");
  end

endmodule
